// File: rtl/voice_mixer_pkg.sv
// Shared constants and types for the voice mixer and its neighbours.
// Contents: voice count and sample/volume widths, the unity-gain and
// volume-shift constants, and the mixer FSM state encoding.
package voice_mixer_pkg;

    localparam int unsigned MIX_N_VOICES  = 8;
    localparam int unsigned MIX_WIDTH     = 24;
    localparam int unsigned MIX_VOL_WIDTH = 9;

    // Master volume is a fixed-point gain with 8 fractional bits.
    localparam int unsigned UNITY_VOL     = 256;
    localparam int unsigned VOL_SHIFT     = 8;

    localparam int unsigned CLIP_CNT_W    = 16;

    // Mixer FSM states, kept as plain constants for legacy tools.
    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] mix_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCUM  = 3'd1;
    localparam logic [2:0] ST_SCALE  = 3'd2;
    localparam logic [2:0] ST_CLIP   = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

endpackage

// File: rtl/voice_mixer_if.sv
// Output-sample handshake between the mixer and the output stage (I2S/DAC).
// Signals: out_sample (signed sample), out_valid, out_ready.
// Modports: master = mixer side, slave = output-stage side.
interface voice_mixer_if #(
    parameter int unsigned WIDTH = 24
);

    logic [WIDTH-1:0] out_sample;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_sample,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_sample,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/voice_mixer_sat_clip.sv
// Combinational signed saturator from IN_W down to OUT_W bits.
// Ports: din (signed, IN_W), dout_c (saturated, OUT_W), clipped_c (saturation
// occurred).
module voice_mixer_sat_clip #(
    parameter int unsigned IN_W  = 29,
    parameter int unsigned OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout_c,
    output logic                    clipped_c
);

    // Bits from the MSB down to the output sign bit must all agree to fit.
    localparam int unsigned EXT_W = IN_W - OUT_W + 1;

    logic [EXT_W-1:0] upper;

    always_comb begin
        upper     = din[IN_W-1:OUT_W-1];
        clipped_c = !((upper == '0) || (upper == '1));
        if (!clipped_c) begin
            dout_c = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout_c = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout_c = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: snapshots all voices on sample_tick, sums enabled voices one
// per cycle, applies master volume ((sum*vol)>>>8), saturates to WIDTH and
// offers the result on a valid/ready handshake.
// Ports: clk, rstn (sync, active-low), sample_tick, voices_in, voice_enable,
// master_volume, out_if (out_sample/out_valid/out_ready), clip_count,
// overrun, clear_status.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int unsigned N_VOICES  = MIX_N_VOICES,
    parameter int unsigned WIDTH     = MIX_WIDTH,
    parameter int unsigned VOL_WIDTH = MIX_VOL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sample_tick,
    input  logic [N_VOICES-1:0][WIDTH-1:0] voices_in,
    input  logic [N_VOICES-1:0]            voice_enable,
    input  logic [VOL_WIDTH-1:0]           master_volume,
    voice_mixer_if.master                  out_if,
    output logic [CLIP_CNT_W-1:0]          clip_count,
    output logic                           overrun,
    input  logic                           clear_status
);

    localparam int unsigned IDX_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int unsigned ACC_W  = WIDTH + $clog2(N_VOICES);
    localparam int unsigned PROD_W = ACC_W + VOL_WIDTH + 1;
    localparam int unsigned SCL_W  = PROD_W - VOL_SHIFT;

    mix_state_t                     state_q, state_next;
    logic [N_VOICES-1:0][WIDTH-1:0] snap_voice_q, snap_voice_next;
    logic [N_VOICES-1:0]            snap_en_q, snap_en_next;
    logic [VOL_WIDTH-1:0]           snap_vol_q, snap_vol_next;
    logic signed [ACC_W-1:0]        acc_q, acc_next;
    logic [IDX_W-1:0]               idx_q, idx_next;
    logic signed [PROD_W-1:0]       prod_q, prod_next;
    logic [WIDTH-1:0]               out_sample_q, out_sample_next;
    logic                           out_valid_q, out_valid_next;
    logic [CLIP_CNT_W-1:0]          clip_count_q, clip_count_next;
    logic                           overrun_q, overrun_next;

    logic signed [ACC_W-1:0]        voice_ext;
    logic signed [SCL_W-1:0]        scaled;
    logic signed [WIDTH-1:0]        sat_value;
    logic                           sat_flag;

    // Sign-extend the currently selected snapshot voice to accumulator width.
    always_comb begin
        voice_ext = {{(ACC_W-WIDTH){snap_voice_q[idx_q][WIDTH-1]}}, snap_voice_q[idx_q]};
    end

    // Dropping the low VOL_SHIFT bits of a signed value is the floor shift.
    always_comb begin
        scaled = prod_q[PROD_W-1:VOL_SHIFT];
    end

    voice_mixer_sat_clip #(
        .IN_W  (SCL_W),
        .OUT_W (WIDTH)
    ) u_sat_clip (
        .din       (scaled),
        .dout_c    (sat_value),
        .clipped_c (sat_flag)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            snap_voice_q <= '0;
            snap_en_q    <= '0;
            snap_vol_q   <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            prod_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            clip_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_next;
            snap_voice_q <= snap_voice_next;
            snap_en_q    <= snap_en_next;
            snap_vol_q   <= snap_vol_next;
            acc_q        <= acc_next;
            idx_q        <= idx_next;
            prod_q       <= prod_next;
            out_sample_q <= out_sample_next;
            out_valid_q  <= out_valid_next;
            clip_count_q <= clip_count_next;
            overrun_q    <= overrun_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next      = state_q;
        snap_voice_next = snap_voice_q;
        snap_en_next    = snap_en_q;
        snap_vol_next   = snap_vol_q;
        acc_next        = acc_q;
        idx_next        = idx_q;
        prod_next       = prod_q;
        out_sample_next = out_sample_q;
        out_valid_next  = out_valid_q;
        clip_count_next = clip_count_q;
        overrun_next    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    snap_voice_next = voices_in;
                    snap_en_next    = voice_enable;
                    snap_vol_next   = master_volume;
                    acc_next        = '0;
                    idx_next        = '0;
                    state_next      = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (snap_en_q[idx_q]) begin
                    acc_next = acc_q + voice_ext;
                end
                idx_next = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_VOICES - 1)) begin
                    state_next = ST_SCALE;
                end
            end
            ST_SCALE: begin
                prod_next  = $signed({{(PROD_W-ACC_W){acc_q[ACC_W-1]}}, acc_q})
                           * $signed({{(PROD_W-VOL_WIDTH){1'b0}}, snap_vol_q});
                state_next = ST_CLIP;
            end
            ST_CLIP: begin
                out_sample_next = sat_value;
                if (sat_flag && (clip_count_q != '1)) begin
                    clip_count_next = clip_count_q + CLIP_CNT_W'(1);
                end
                state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                // First cycle here raises valid; afterwards wait for ready.
                if (!out_valid_q) begin
                    out_valid_next = 1'b1;
                end else if (out_if.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Any tick the FSM cannot take is lost; flag it.
        if (sample_tick && (state_q != ST_IDLE)) begin
            overrun_next = 1'b1;
        end

        if (clear_status) begin
            clip_count_next = '0;
            overrun_next    = 1'b0;
        end
    end

    assign out_if.out_sample = out_sample_q;
    assign out_if.out_valid  = out_valid_q;
    assign clip_count        = clip_count_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed cases plus randomized samples
// compared against an arithmetic mixing model.
module tb_voice_mixer;

    localparam int unsigned NV = 8;
    localparam int unsigned W  = 24;
    localparam int unsigned VW = 9;
    localparam longint SMAX = 64'sd8388607;
    localparam longint SMIN = -64'sd8388608;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     sample_tick = 1'b0;
    logic                     clear_status = 1'b0;
    logic [NV-1:0][W-1:0]     voices_in = '0;
    logic [NV-1:0]            voice_enable = '0;
    logic [VW-1:0]            master_volume = '0;
    logic [15:0]              clip_count;
    logic                     overrun;

    voice_mixer_if #(.WIDTH(W)) mix_if ();

    voice_mixer #(
        .N_VOICES  (NV),
        .WIDTH     (W),
        .VOL_WIDTH (VW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sample_tick   (sample_tick),
        .voices_in     (voices_in),
        .voice_enable  (voice_enable),
        .master_volume (master_volume),
        .out_if        (mix_if),
        .clip_count    (clip_count),
        .overrun       (overrun),
        .clear_status  (clear_status)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint exp_sample = 0;
    bit     exp_clipped = 1'b0;
    longint exp_clip = 0;
    longint exp_overrun = 0;

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    // Sum of enabled voices times volume, floored by 256, then saturated.
    function automatic longint mix_model(input logic [NV-1:0][W-1:0] v,
                                         input logic [NV-1:0] en,
                                         input logic [VW-1:0] vol,
                                         output bit clipped);
        longint sum = 0;
        longint scaled;
        for (int i = 0; i < NV; i++) begin
            if (en[i]) sum += longint'($signed(v[i]));
        end
        scaled  = (sum * longint'(vol)) >>> 8;
        clipped = (scaled > SMAX) || (scaled < SMIN);
        if (scaled > SMAX) return SMAX;
        if (scaled < SMIN) return SMIN;
        return scaled;
    endfunction

    function automatic longint dut_sample();
        return longint'($signed(mix_if.out_sample));
    endfunction

    // Tick at one posedge, then scramble inputs to prove the snapshot.
    task automatic issue_tick(input logic [NV-1:0][W-1:0] v,
                              input logic [NV-1:0] en,
                              input logic [VW-1:0] vol);
        bit c;
        @(negedge clk);
        voices_in     = v;
        voice_enable  = en;
        master_volume = vol;
        sample_tick   = 1'b1;
        exp_sample    = mix_model(v, en, vol, c);
        exp_clipped   = c;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < NV; i++) voices_in[i] = W'($urandom);
        voice_enable  = NV'($urandom);
        master_volume = VW'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!mix_if.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (exp_clipped && exp_clip < 65535) exp_clip++;
        check({tag, "_latency"}, longint'(lat), 11);
        check({tag, "_sample"}, dut_sample(), exp_sample);
        check({tag, "_clip_count"}, longint'(clip_count), exp_clip);
    endtask

    task automatic handshake(input string tag, input bit tick_same);
        @(negedge clk);
        mix_if.out_ready = 1'b1;
        sample_tick      = tick_same;
        @(negedge clk);
        mix_if.out_ready = 1'b0;
        sample_tick      = 1'b0;
        if (tick_same) exp_overrun = 1;
        check({tag, "_valid_drop"}, longint'(mix_if.out_valid), 0);
        check({tag, "_overrun"}, longint'(overrun), exp_overrun);
    endtask

    initial begin
        logic [NV-1:0][W-1:0] v;
        int seen;

        mix_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", longint'(mix_if.out_valid), 0);
        check("rst_sample", dut_sample(), 0);
        check("rst_clip", longint'(clip_count), 0);
        check("rst_overrun", longint'(overrun), 0);
        rstn = 1'b1;

        // All voices 1000 at unity gain.
        for (int i = 0; i < NV; i++) v[i] = W'(1000);
        issue_tick(v, 8'hFF, 9'd256);
        wait_valid("unity");
        handshake("unity", 1'b0);

        // Sparse enable at half gain.
        for (int i = 0; i < NV; i++) v[i] = W'(100 * (i + 1));
        issue_tick(v, 8'b0000_0101, 9'd128);
        wait_valid("sparse");
        check("sparse_const", dut_sample(), 200);
        handshake("sparse", 1'b0);

        // Floor rounding of negative results.
        v = '0;
        v[0] = W'(-3);
        issue_tick(v, 8'h01, 9'd128);
        wait_valid("floor_a");
        check("floor_a_const", dut_sample(), -2);
        handshake("floor_a", 1'b0);
        v[0] = W'(-1);
        issue_tick(v, 8'h01, 9'd1);
        wait_valid("floor_b");
        handshake("floor_b", 1'b0);

        // Positive and negative saturation, then clear.
        for (int i = 0; i < NV; i++) v[i] = W'(8388607);
        issue_tick(v, 8'hFF, 9'd256);
        wait_valid("clip_pos");
        handshake("clip_pos", 1'b0);
        for (int i = 0; i < NV; i++) v[i] = W'(-8388608);
        issue_tick(v, 8'hFF, 9'd256);
        wait_valid("clip_neg");
        check("clip_neg_cnt", longint'(clip_count), 2);
        handshake("clip_neg", 1'b0);
        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        exp_clip = 0;
        exp_overrun = 0;
        check("clear_clip", longint'(clip_count), 0);

        // Stall the output, tick during the stall, then release.
        for (int i = 0; i < NV; i++) v[i] = W'(-5000 * i);
        issue_tick(v, 8'hAA, 9'd300);
        wait_valid("stall");
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        exp_overrun = 1;
        repeat (2) @(negedge clk);
        check("stall_overrun", longint'(overrun), 1);
        check("stall_hold_sample", dut_sample(), exp_sample);
        check("stall_hold_valid", longint'(mix_if.out_valid), 1);
        handshake("stall", 1'b0);
        for (int i = 0; i < NV; i++) v[i] = W'(7 * i + 1);
        issue_tick(v, 8'hFF, 9'd256);
        wait_valid("fresh");
        handshake("fresh", 1'b1);

        // Reset during accumulation abandons the sample.
        for (int i = 0; i < NV; i++) v[i] = W'(8388607);
        issue_tick(v, 8'hFF, 9'd511);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_clip = 0;
        exp_overrun = 0;
        check("midrst_valid", longint'(mix_if.out_valid), 0);
        check("midrst_sample", dut_sample(), 0);
        check("midrst_clip", longint'(clip_count), 0);
        check("midrst_overrun", longint'(overrun), 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (mix_if.out_valid) seen++;
        end
        check("midrst_no_output", longint'(seen), 0);
        for (int i = 0; i < NV; i++) v[i] = W'(-(i * 123));
        issue_tick(v, 8'h3C, 9'd200);
        wait_valid("post_rst");
        handshake("post_rst", 1'b0);

        // Randomized samples against the model.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 1) == 0) v[i] = W'($urandom);
                else v[i] = W'($signed(12'($urandom)));
            end
            issue_tick(v, NV'($urandom), VW'($urandom));
            wait_valid("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake("rand", bit'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
